amo_bank_arbiter: RTL and testbench

Round-robin arbiter that shares one AMO-capable SRAM bank (atomic shim plus SRAM) among `NumIn` requesters. It forwards one request per cycle to the bank port and locks arbitration during the shim's second (write-back) AMO cycle. It routes the one-cycle-later read response back to the winning requester. Optionally it implements LR/SC reservations in front of the bank.

---
 rtl/amo_bank_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_amo_bank_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/amo_bank_arbiter.sv
// ---------------------------------------------------------------------------
// amo_bank_arbiter
//
// Round-robin arbiter sharing one AMO-capable SRAM bank (atomic shim + SRAM)
// among NumIn requesters. One request per cycle is forwarded to the bank;
// arbitration is frozen for the cycle after a shim AMO (1..A) is granted,
// because the shim uses that cycle for its write-back. The read response
// arrives one cycle after the grant and is routed to the requester that won.
//
// Optional feature macro: AMO_BANK_ARB_LRSC_EN
//   When defined, LR (B) / SC (C) are resolved here using per-requester
//   reservation registers. A failing SC never reaches the bank.
//   When undefined, codes B and C are forwarded to the bank untouched.
//
// Ports
//   clk_i, rst_i          clock (rising edge), async active-high reset
//   req_i / gnt_o         per-requester request / combinational one-hot grant
//   add_i, amo_i, wen_i,  per-requester address, AMO code, write enable,
//   wdata_i, be_i         write data and byte enables
//   rvalid_o, rdata_o     one-hot response valid and shared response data
//   bank_*_o              request fields of the selected requester to the bank
//   bank_gnt_i            bank accepts the current request
//   bank_rdata_i          bank read data, one cycle after a granted request
// ---------------------------------------------------------------------------
module amo_bank_arbiter #(
    parameter int NumIn        = 4,
    parameter int AddrMemWidth = 32,
    parameter int DataWidth    = 64
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumIn-1:0]                      req_i,
    output logic [NumIn-1:0]                      gnt_o,
    input  logic [NumIn-1:0][AddrMemWidth-1:0]    add_i,
    input  logic [NumIn-1:0][3:0]                 amo_i,
    input  logic [NumIn-1:0]                      wen_i,
    input  logic [NumIn-1:0][DataWidth-1:0]       wdata_i,
    input  logic [NumIn-1:0][DataWidth/8-1:0]     be_i,
    output logic [NumIn-1:0]                      rvalid_o,
    output logic [DataWidth-1:0]                  rdata_o,
    output logic                                  bank_req_o,
    output logic [AddrMemWidth-1:0]               bank_add_o,
    output logic [3:0]                            bank_amo_o,
    output logic                                  bank_wen_o,
    output logic [DataWidth-1:0]                  bank_wdata_o,
    output logic [DataWidth/8-1:0]                bank_be_o,
    input  logic                                  bank_gnt_i,
    input  logic [DataWidth-1:0]                  bank_rdata_i
);

    localparam int IdxW = (NumIn > 1) ? $clog2(NumIn) : 1;

    typedef enum logic [1:0] {
        RESP_BANK    = 2'd0,
        RESP_SC_OK   = 2'd1,
        RESP_SC_FAIL = 2'd2
    } resp_kind_e;

    typedef struct packed {
        logic            valid;
        logic [IdxW-1:0] idx;
        resp_kind_e      kind;
    } resp_t;

    logic [IdxW-1:0]         rr_q, rr_d;
    logic                    lock_q, lock_d;
    resp_t                   resp_q, resp_d;

    logic                    any_req;
    logic                    found;
    logic [IdxW-1:0]         win;
    logic [3:0]              win_amo;
    logic [AddrMemWidth-1:0] win_add;
    logic                    is_amo;
    logic                    grant;
    logic                    sc_ok;
    logic                    sc_fail;

`ifdef AMO_BANK_ARB_LRSC_EN
    localparam logic [3:0] AmoLr = 4'hB;
    localparam logic [3:0] AmoSc = 4'hC;

    logic [NumIn-1:0]                   resv_v_q, resv_v_d;
    logic [NumIn-1:0][AddrMemWidth-1:0] resv_a_q, resv_a_d;
    logic                               is_lr;
`endif

    // Pick the first requester at or after the round-robin pointer, wrapping.
    always_comb begin
        any_req = |req_i;
        found   = 1'b0;
        win     = '0;
        for (int i = 0; i < NumIn; i++) begin
            if (!found && req_i[(int'(rr_q) + i) % NumIn]) begin
                found = 1'b1;
                win   = IdxW'((int'(rr_q) + i) % NumIn);
            end
        end
    end

    always_comb begin
        win_amo      = amo_i[win];
        win_add      = add_i[win];
        is_amo       = (win_amo >= 4'h1) && (win_amo <= 4'hA);
        bank_add_o   = win_add;
        bank_amo_o   = win_amo;
        bank_wen_o   = wen_i[win];
        bank_wdata_o = wdata_i[win];
        bank_be_o    = be_i[win];
        sc_ok        = 1'b0;
        sc_fail      = 1'b0;
`ifdef AMO_BANK_ARB_LRSC_EN
        is_lr        = 1'b0;
        // LR becomes a plain read; SC becomes a plain write only when the
        // issuer still holds a reservation on exactly this address.
        if (win_amo == AmoLr) begin
            is_lr      = 1'b1;
            bank_amo_o = 4'h0;
            bank_wen_o = 1'b0;
        end else if (win_amo == AmoSc) begin
            if (resv_v_q[win] && (resv_a_q[win] == win_add)) begin
                sc_ok      = 1'b1;
                bank_amo_o = 4'h0;
                bank_wen_o = 1'b1;
            end else begin
                sc_fail    = 1'b1;
            end
        end
`endif
        // A failing SC is answered locally, so it neither needs nor waits for the bank.
        bank_req_o = any_req && !lock_q && !sc_fail;
        grant      = any_req && !lock_q && (sc_fail || bank_gnt_i);
        gnt_o      = '0;
        gnt_o[win] = grant;
    end

    always_comb begin
        rr_d   = rr_q;
        lock_d = 1'b0;
        resp_d = '{valid: grant, idx: win, kind: RESP_BANK};
        if (sc_ok) begin
            resp_d.kind = RESP_SC_OK;
        end else if (sc_fail) begin
            resp_d.kind = RESP_SC_FAIL;
        end
        if (grant) begin
            rr_d   = (int'(win) == NumIn - 1) ? '0 : win + IdxW'(1);
            // Only shim AMOs occupy the bank for a second (write-back) cycle.
            lock_d = is_amo;
        end
    end

    always_comb begin
        rvalid_o              = '0;
        rvalid_o[resp_q.idx]  = resp_q.valid;
        case (resp_q.kind)
            RESP_SC_OK:   rdata_o = '0;
            RESP_SC_FAIL: rdata_o = DataWidth'(1);
            default:      rdata_o = bank_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q   <= '0;
            lock_q <= 1'b0;
            resp_q <= '{valid: 1'b0, idx: '0, kind: RESP_BANK};
        end else begin
            rr_q   <= rr_d;
            lock_q <= lock_d;
            resp_q <= resp_d;
        end
    end

`ifdef AMO_BANK_ARB_LRSC_EN
    // Any write reaching the bank (store, shim AMO, successful SC) kills all
    // reservations on that address; a new LR is applied afterwards so it survives.
    always_comb begin
        resv_v_d = resv_v_q;
        resv_a_d = resv_a_q;
        if (grant) begin
            if (!sc_fail && (bank_wen_o || is_amo)) begin
                for (int m = 0; m < NumIn; m++) begin
                    if (resv_a_q[m] == win_add) begin
                        resv_v_d[m] = 1'b0;
                    end
                end
            end
            if (sc_fail) begin
                resv_v_d[win] = 1'b0;
            end
            if (is_lr) begin
                resv_v_d[win] = 1'b1;
                resv_a_d[win] = win_add;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resv_v_q <= '0;
            resv_a_q <= '0;
        end else begin
            resv_v_q <= resv_v_d;
            resv_a_q <= resv_a_d;
        end
    end
`endif

endmodule

// File: tb/tb_amo_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_amo_bank_arbiter
//
// Directed bench for amo_bank_arbiter (NumIn=4, 32-bit addresses, 64-bit
// data). Inputs change on the falling clock edge and outputs are sampled 1ns
// later, well away from the rising edge. Reservation scenarios are compiled
// in when AMO_BANK_ARB_LRSC_EN is defined; otherwise B/C pass-through is
// checked instead.
// ---------------------------------------------------------------------------
module tb_amo_bank_arbiter;

    localparam int NumIn = 4;
    localparam int AW    = 32;
    localparam int DW    = 64;

    logic                       clk_i = 1'b0;
    logic                       rst_i;
    logic [NumIn-1:0]           req_i;
    logic [NumIn-1:0]           gnt_o;
    logic [NumIn-1:0][AW-1:0]   add_i;
    logic [NumIn-1:0][3:0]      amo_i;
    logic [NumIn-1:0]           wen_i;
    logic [NumIn-1:0][DW-1:0]   wdata_i;
    logic [NumIn-1:0][DW/8-1:0] be_i;
    logic [NumIn-1:0]           rvalid_o;
    logic [DW-1:0]              rdata_o;
    logic                       bank_req_o;
    logic [AW-1:0]              bank_add_o;
    logic [3:0]                 bank_amo_o;
    logic                       bank_wen_o;
    logic [DW-1:0]              bank_wdata_o;
    logic [DW/8-1:0]            bank_be_o;
    logic                       bank_gnt_i;
    logic [DW-1:0]              bank_rdata_i;

    int n_checks = 0;
    int n_fail   = 0;

    amo_bank_arbiter #(
        .NumIn        (NumIn),
        .AddrMemWidth (AW),
        .DataWidth    (DW)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .add_i        (add_i),
        .amo_i        (amo_i),
        .wen_i        (wen_i),
        .wdata_i      (wdata_i),
        .be_i         (be_i),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .bank_req_o   (bank_req_o),
        .bank_add_o   (bank_add_o),
        .bank_amo_o   (bank_amo_o),
        .bank_wen_o   (bank_wen_o),
        .bank_wdata_o (bank_wdata_o),
        .bank_be_o    (bank_be_o),
        .bank_gnt_i   (bank_gnt_i),
        .bank_rdata_i (bank_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Quiet all requesters; the bank is left willing to grant.
    task automatic drive_idle();
        req_i      = '0;
        add_i      = '0;
        amo_i      = '0;
        wen_i      = '0;
        wdata_i    = '0;
        be_i       = '0;
        bank_gnt_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i        = 1'b1;
        drive_idle();
        bank_rdata_i = 64'h1234;
        #2;
        n_checks++; if (gnt_o !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_gnt: got %b expected %b", gnt_o, 4'b0000); end
        n_checks++; if (rvalid_o !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_rvalid: got %b expected %b", rvalid_o, 4'b0000); end
        n_checks++; if (bank_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_bank_req: got %b expected %b", bank_req_o, 1'b0); end
        n_checks++; if (rdata_o !== 64'h1234) begin n_fail++; $display("[TB] FAIL reset_rdata: got %h expected %h", rdata_o, 64'h1234); end
        @(negedge clk_i); rst_i = 1'b0; #1;
        n_checks++; if (gnt_o !== 4'b0000) begin n_fail++; $display("[TB] FAIL idle_gnt: got %b expected %b", gnt_o, 4'b0000); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        logic [3:0] exp_v;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i); drive_idle(); req_i = 4'b1111; #1;
            exp_g = 4'b0001 << (k % 4);
            n_checks++; if (gnt_o !== exp_g) begin n_fail++; $display("[TB] FAIL rr_gnt[%0d]: got %b expected %b", k, gnt_o, exp_g); end
            if (k > 0) begin
                exp_v = 4'b0001 << ((k - 1) % 4);
                n_checks++; if (rvalid_o !== exp_v) begin n_fail++; $display("[TB] FAIL rr_rvalid[%0d]: got %b expected %b", k, rvalid_o, exp_v); end
            end
        end
        @(negedge clk_i); drive_idle(); #1;
        n_checks++; if (gnt_o !== 4'b0000) begin n_fail++; $display("[TB] FAIL rr_idle_gnt: got %b expected %b", gnt_o, 4'b0000); end
        n_checks++; if (rvalid_o !== 4'b0001) begin n_fail++; $display("[TB] FAIL rr_last_rvalid: got %b expected %b", rvalid_o, 4'b0001); end
    endtask

    task automatic test_read_response();
        @(negedge clk_i); drive_idle(); req_i[2] = 1'b1; add_i[2] = 32'h10; #1;
        n_checks++; if (gnt_o !== 4'b0100) begin n_fail++; $display("[TB] FAIL rd_gnt: got %b expected %b", gnt_o, 4'b0100); end
        n_checks++; if (bank_req_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rd_bank_req: got %b expected %b", bank_req_o, 1'b1); end
        n_checks++; if (bank_add_o !== 32'h10) begin n_fail++; $display("[TB] FAIL rd_bank_add: got %h expected %h", bank_add_o, 32'h10); end
        n_checks++; if (bank_wen_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_bank_wen: got %b expected %b", bank_wen_o, 1'b0); end
        @(negedge clk_i); drive_idle(); bank_rdata_i = 64'hDEAD_BEEF; #1;
        n_checks++; if (rvalid_o !== 4'b0100) begin n_fail++; $display("[TB] FAIL rd_rvalid: got %b expected %b", rvalid_o, 4'b0100); end
        n_checks++; if (rdata_o !== 64'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL rd_rdata: got %h expected %h", rdata_o, 64'hDEAD_BEEF); end
    endtask

    task automatic test_amo_lock();
        // Point the round-robin pointer at requester 1 first.
        @(negedge clk_i); drive_idle(); req_i = 4'b0001; #1;
        n_checks++; if (gnt_o !== 4'b0001) begin n_fail++; $display("[TB] FAIL amo_setup_gnt: got %b expected %b", gnt_o, 4'b0001); end
        @(negedge clk_i); drive_idle(); req_i = 4'b1010; amo_i[1] = 4'h2; wdata_i[1] = 64'h5; #1;
        n_checks++; if (gnt_o !== 4'b0010) begin n_fail++; $display("[TB] FAIL amo_gnt_n: got %b expected %b", gnt_o, 4'b0010); end
        n_checks++; if (bank_amo_o !== 4'h2) begin n_fail++; $display("[TB] FAIL amo_bank_amo: got %h expected %h", bank_amo_o, 4'h2); end
        @(negedge clk_i); drive_idle(); req_i = 4'b1000; bank_rdata_i = 64'h55; #1;
        n_checks++; if (gnt_o !== 4'b0000) begin n_fail++; $display("[TB] FAIL amo_lock_gnt: got %b expected %b", gnt_o, 4'b0000); end
        n_checks++; if (bank_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL amo_lock_bank_req: got %b expected %b", bank_req_o, 1'b0); end
        n_checks++; if (rvalid_o !== 4'b0010) begin n_fail++; $display("[TB] FAIL amo_rvalid: got %b expected %b", rvalid_o, 4'b0010); end
        n_checks++; if (rdata_o !== 64'h55) begin n_fail++; $display("[TB] FAIL amo_old_value: got %h expected %h", rdata_o, 64'h55); end
        @(negedge clk_i); drive_idle(); req_i = 4'b1000; #1;
        n_checks++; if (gnt_o !== 4'b1000) begin n_fail++; $display("[TB] FAIL amo_after_gnt: got %b expected %b", gnt_o, 4'b1000); end
        @(negedge clk_i); drive_idle(); #1;
        n_checks++; if (rvalid_o !== 4'b1000) begin n_fail++; $display("[TB] FAIL amo_after_rvalid: got %b expected %b", rvalid_o, 4'b1000); end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i); drive_idle(); req_i = 4'b0011; bank_gnt_i = 1'b0; #1;
            n_checks++; if (gnt_o !== 4'b0000) begin n_fail++; $display("[TB] FAIL bp_gnt[%0d]: got %b expected %b", k, gnt_o, 4'b0000); end
            n_checks++; if (bank_req_o !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_bank_req[%0d]: got %b expected %b", k, bank_req_o, 1'b1); end
            n_checks++; if (rvalid_o !== 4'b0000) begin n_fail++; $display("[TB] FAIL bp_rvalid[%0d]: got %b expected %b", k, rvalid_o, 4'b0000); end
            n_checks++; if (dut.rr_q !== 2'd0) begin n_fail++; $display("[TB] FAIL bp_rr[%0d]: got %0d expected %0d", k, dut.rr_q, 0); end
        end
        @(negedge clk_i); drive_idle(); req_i = 4'b0011; #1;
        n_checks++; if (gnt_o !== 4'b0001) begin n_fail++; $display("[TB] FAIL bp_release_gnt: got %b expected %b", gnt_o, 4'b0001); end
        @(negedge clk_i); drive_idle(); #1;
        n_checks++; if (rvalid_o !== 4'b0001) begin n_fail++; $display("[TB] FAIL bp_rvalid_after: got %b expected %b", rvalid_o, 4'b0001); end
        n_checks++; if (dut.rr_q !== 2'd1) begin n_fail++; $display("[TB] FAIL bp_rr_after: got %0d expected %0d", dut.rr_q, 1); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i); drive_idle(); req_i[2] = 1'b1; #1;
            n_checks++; if (gnt_o !== 4'b0100) begin n_fail++; $display("[TB] FAIL b2b_load_gnt[%0d]: got %b expected %b", k, gnt_o, 4'b0100); end
            if (k > 0) begin
                n_checks++; if (rvalid_o !== 4'b0100) begin n_fail++; $display("[TB] FAIL b2b_load_rvalid[%0d]: got %b expected %b", k, rvalid_o, 4'b0100); end
            end
        end
        // A lone AMO requester gets the bank every other cycle.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i); drive_idle(); req_i[2] = 1'b1; amo_i[2] = 4'h3; #1;
            n_checks++; if (gnt_o !== ((k == 1) ? 4'b0000 : 4'b0100)) begin n_fail++; $display("[TB] FAIL b2b_amo_gnt[%0d]: got %b expected %b", k, gnt_o, ((k == 1) ? 4'b0000 : 4'b0100)); end
        end
        @(negedge clk_i); drive_idle(); #1;
        @(negedge clk_i); drive_idle(); #1;
    endtask

    task automatic test_field_mux();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i); drive_idle();
            req_i[3] = 1'b1; amo_i[3] = 4'hD; wen_i[3] = 1'b1; add_i[3] = 32'h80;
            wdata_i[3] = 64'hA5A5_0000_1111_5A5A; be_i[3] = 8'h0F; #1;
            n_checks++; if (gnt_o !== 4'b1000) begin n_fail++; $display("[TB] FAIL mux_gnt[%0d]: got %b expected %b", k, gnt_o, 4'b1000); end
            n_checks++; if (bank_amo_o !== 4'hD) begin n_fail++; $display("[TB] FAIL mux_amo[%0d]: got %h expected %h", k, bank_amo_o, 4'hD); end
            n_checks++; if (bank_wen_o !== 1'b1) begin n_fail++; $display("[TB] FAIL mux_wen[%0d]: got %b expected %b", k, bank_wen_o, 1'b1); end
            n_checks++; if (bank_add_o !== 32'h80) begin n_fail++; $display("[TB] FAIL mux_add[%0d]: got %h expected %h", k, bank_add_o, 32'h80); end
            n_checks++; if (bank_wdata_o !== 64'hA5A5_0000_1111_5A5A) begin n_fail++; $display("[TB] FAIL mux_wdata[%0d]: got %h expected %h", k, bank_wdata_o, 64'hA5A5_0000_1111_5A5A); end
            n_checks++; if (bank_be_o !== 8'h0F) begin n_fail++; $display("[TB] FAIL mux_be[%0d]: got %h expected %h", k, bank_be_o, 8'h0F); end
        end
        @(negedge clk_i); drive_idle(); #1;
    endtask

`ifdef AMO_BANK_ARB_LRSC_EN
    task automatic test_lrsc_success();
        @(negedge clk_i); drive_idle(); req_i[0] = 1'b1; amo_i[0] = 4'hB; add_i[0] = 32'h40; #1;
        n_checks++; if (gnt_o !== 4'b0001) begin n_fail++; $display("[TB] FAIL lr_gnt: got %b expected %b", gnt_o, 4'b0001); end
        n_checks++; if (bank_amo_o !== 4'h0) begin n_fail++; $display("[TB] FAIL lr_bank_amo: got %h expected %h", bank_amo_o, 4'h0); end
        n_checks++; if (bank_wen_o !== 1'b0) begin n_fail++; $display("[TB] FAIL lr_bank_wen: got %b expected %b", bank_wen_o, 1'b0); end
        @(negedge clk_i); drive_idle(); req_i[0] = 1'b1; amo_i[0] = 4'hC; add_i[0] = 32'h40; bank_rdata_i = 64'hFF; #1;
        n_checks++; if (bank_req_o !== 1'b1) begin n_fail++; $display("[TB] FAIL sc_ok_bank_req: got %b expected %b", bank_req_o, 1'b1); end
        n_checks++; if (bank_wen_o !== 1'b1) begin n_fail++; $display("[TB] FAIL sc_ok_bank_wen: got %b expected %b", bank_wen_o, 1'b1); end
        n_checks++; if (bank_amo_o !== 4'h0) begin n_fail++; $display("[TB] FAIL sc_ok_bank_amo: got %h expected %h", bank_amo_o, 4'h0); end
        n_checks++; if (gnt_o !== 4'b0001) begin n_fail++; $display("[TB] FAIL sc_ok_gnt: got %b expected %b", gnt_o, 4'b0001); end
        @(negedge clk_i); drive_idle(); #1;
        n_checks++; if (rvalid_o !== 4'b0001) begin n_fail++; $display("[TB] FAIL sc_ok_rvalid: got %b expected %b", rvalid_o, 4'b0001); end
        n_checks++; if (rdata_o !== 64'h0) begin n_fail++; $display("[TB] FAIL sc_ok_rdata: got %h expected %h", rdata_o, 64'h0); end
    endtask

    task automatic test_lrsc_fail();
        @(negedge clk_i); drive_idle(); req_i[0] = 1'b1; amo_i[0] = 4'hB; add_i[0] = 32'h40; #1;
        @(negedge clk_i); drive_idle(); req_i[1] = 1'b1; wen_i[1] = 1'b1; add_i[1] = 32'h40; #1;
        n_checks++; if (gnt_o !== 4'b0010) begin n_fail++; $display("[TB] FAIL st_gnt: got %b expected %b", gnt_o, 4'b0010); end
        // Bank refuses; a failing SC must still be granted without it.
        @(negedge clk_i); drive_idle(); req_i[0] = 1'b1; amo_i[0] = 4'hC; add_i[0] = 32'h40; bank_gnt_i = 1'b0; bank_rdata_i = 64'hFF; #1;
        n_checks++; if (bank_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL sc_fail_bank_req: got %b expected %b", bank_req_o, 1'b0); end
        n_checks++; if (gnt_o !== 4'b0001) begin n_fail++; $display("[TB] FAIL sc_fail_gnt: got %b expected %b", gnt_o, 4'b0001); end
        @(negedge clk_i); drive_idle(); #1;
        n_checks++; if (rvalid_o !== 4'b0001) begin n_fail++; $display("[TB] FAIL sc_fail_rvalid: got %b expected %b", rvalid_o, 4'b0001); end
        n_checks++; if (rdata_o !== 64'h1) begin n_fail++; $display("[TB] FAIL sc_fail_rdata: got %h expected %h", rdata_o, 64'h1); end
    endtask

    task automatic test_lrsc_mismatch();
        @(negedge clk_i); drive_idle(); req_i[0] = 1'b1; amo_i[0] = 4'hB; add_i[0] = 32'h40; #1;
        @(negedge clk_i); drive_idle(); req_i[0] = 1'b1; amo_i[0] = 4'hC; add_i[0] = 32'h44; #1;
        n_checks++; if (bank_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL sc_mm_bank_req: got %b expected %b", bank_req_o, 1'b0); end
        @(negedge clk_i); drive_idle(); req_i[0] = 1'b1; amo_i[0] = 4'hC; add_i[0] = 32'h40; #1;
        n_checks++; if (rdata_o !== 64'h1) begin n_fail++; $display("[TB] FAIL sc_mm_rdata: got %h expected %h", rdata_o, 64'h1); end
        n_checks++; if (bank_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL sc_mm_resv_cleared: got %b expected %b", bank_req_o, 1'b0); end
        @(negedge clk_i); drive_idle(); #1;
        n_checks++; if (rdata_o !== 64'h1) begin n_fail++; $display("[TB] FAIL sc_mm_second_rdata: got %h expected %h", rdata_o, 64'h1); end
    endtask
`else
    task automatic test_lrsc_passthrough();
        @(negedge clk_i); drive_idle(); req_i[0] = 1'b1; amo_i[0] = 4'hB; add_i[0] = 32'h40; #1;
        n_checks++; if (bank_amo_o !== 4'hB) begin n_fail++; $display("[TB] FAIL pass_lr_amo: got %h expected %h", bank_amo_o, 4'hB); end
        n_checks++; if (gnt_o !== 4'b0001) begin n_fail++; $display("[TB] FAIL pass_lr_gnt: got %b expected %b", gnt_o, 4'b0001); end
        @(negedge clk_i); drive_idle(); req_i[0] = 1'b1; amo_i[0] = 4'hC; wen_i[0] = 1'b1; add_i[0] = 32'h44; bank_rdata_i = 64'h77; #1;
        n_checks++; if (gnt_o !== 4'b0001) begin n_fail++; $display("[TB] FAIL pass_sc_gnt: got %b expected %b", gnt_o, 4'b0001); end
        n_checks++; if (bank_req_o !== 1'b1) begin n_fail++; $display("[TB] FAIL pass_sc_bank_req: got %b expected %b", bank_req_o, 1'b1); end
        n_checks++; if (bank_amo_o !== 4'hC) begin n_fail++; $display("[TB] FAIL pass_sc_amo: got %h expected %h", bank_amo_o, 4'hC); end
        n_checks++; if (rdata_o !== 64'h77) begin n_fail++; $display("[TB] FAIL pass_lr_rdata: got %h expected %h", rdata_o, 64'h77); end
        @(negedge clk_i); drive_idle(); #1;
        n_checks++; if (rdata_o !== 64'h77) begin n_fail++; $display("[TB] FAIL pass_sc_rdata: got %h expected %h", rdata_o, 64'h77); end
    endtask
`endif

    task automatic test_reset_during_lock();
        @(negedge clk_i); drive_idle(); req_i[0] = 1'b1; amo_i[0] = 4'h2; #1;
        n_checks++; if (gnt_o !== 4'b0001) begin n_fail++; $display("[TB] FAIL rl_amo_gnt: got %b expected %b", gnt_o, 4'b0001); end
        @(negedge clk_i); drive_idle(); req_i[0] = 1'b1; #1;
        n_checks++; if (gnt_o !== 4'b0000) begin n_fail++; $display("[TB] FAIL rl_locked_gnt: got %b expected %b", gnt_o, 4'b0000); end
        rst_i = 1'b1; #1; rst_i = 1'b0; #1;
        n_checks++; if (gnt_o !== 4'b0001) begin n_fail++; $display("[TB] FAIL rl_unlocked_gnt: got %b expected %b", gnt_o, 4'b0001); end
        n_checks++; if (rvalid_o !== 4'b0000) begin n_fail++; $display("[TB] FAIL rl_rvalid: got %b expected %b", rvalid_o, 4'b0000); end
        @(negedge clk_i); drive_idle(); #1;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_read_response();
        test_amo_lock();
        test_backpressure();
        test_back_to_back();
        test_field_mux();
`ifdef AMO_BANK_ARB_LRSC_EN
        test_lrsc_success();
        test_lrsc_fail();
        test_lrsc_mismatch();
`else
        test_lrsc_passthrough();
`endif
        test_reset_during_lock();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule
